mem_port_arb: RTL and testbench
===============================

Name: mem_port_arb

Overview:
- Arbiter and sequencer that shares the single-port SISC main memory between two requesters: instruction fetch (IR load) and data access (LOD/STR/SWP).
- Sits between ctrl/datapath and the memory model. Round-robins on conflict, latches the granted address/data, drives the memory port, waits the memory read latency, and returns a one-cycle ack with registered read data.

Parameters:
- AW, 16, address width.
- DW, 32, data width.
- RD_LAT, 1, memory read latency in cycles (mem_rdata valid RD_LAT cycles after the mem_en cycle); legal range 1..4.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_f  input  1  asynchronous active-low reset.
- if_req  input  1  fetch request; held until if_ack.
- if_addr  input  AW  fetch address; stable while if_req high.
- if_ack  output  1  one-cycle pulse: fetch complete, if_rdata valid.
- if_rdata  output  DW  fetched instruction; holds value until next fetch ack.
- d_req  input  1  data request; held until d_ack.
- d_we  input  1  1 = store, 0 = load; stable while d_req high.
- d_addr  input  AW  data address.
- d_wdata  input  DW  store data.
- d_ack  output  1  one-cycle pulse: data access complete.
- d_rdata  output  DW  load data; holds value until next load ack.
- mem_en  output  1  memory access strobe (one cycle per access).
- mem_we  output  1  memory write enable, qualified by mem_en.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst_f low, asynchronous): state=IDLE. All outputs 0: mem_en, mem_we, mem_addr, mem_wdata, if_ack, d_ack, if_rdata, d_rdata, busy. last_grant=DATA, so fetch wins the first tie. Lat counter = 0. A reset mid-access abandons the access with no ack.
- States: IDLE, ISSUE, WAIT, ACK. All outputs are registered.
- IDLE: sample requests each edge.
  - Only one request high: grant it.
  - Both high: grant the requester that is not last_grant.
  - On grant: latch addr/we/wdata (fetch forces we=0), update last_grant, go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (1 cycle): mem_en=1, mem_we=latched we, mem_addr/mem_wdata=latched values.
  - Write: go to ACK.
  - Read: go to WAIT with counter loaded RD_LAT.
- WAIT: mem_en=0. Counter decrements each cycle. In the cycle the counter equals 1, capture mem_rdata into the granted requester's rdata register at the edge, then go to ACK. WAIT lasts exactly RD_LAT cycles.
- ACK (1 cycle): pulse the granted requester's ack. Return to IDLE unconditionally; requests are not sampled at this edge.
- Requester rule: drop req at the edge ending the ack cycle. A req still high in the first IDLE cycle is a new request.
- Latency from the IDLE edge that samples req:
  - Read: ack in cycle N+2+RD_LAT.
  - Write: ack in cycle N+2.
- Throughput: at most one access in flight. A loser's request stays pending and is granted at the next IDLE sample; no starvation under round-robin.
- Request changes (addr/we/wdata) after grant are ignored; the latched values are used.
- if_ack and d_ack are never high in the same cycle. mem_we is never high without mem_en.
- mem_addr/mem_wdata hold their last values outside ISSUE. Verification checks them only when mem_en=1.

Decomposition:
- Shared package sisc_pkg: state encoding (IDLE=0, ISSUE=1, WAIT=2, ACK=3), grant id constants (GNT_IF=0, GNT_D=1), AW/DW defaults.
- One natural sub-module: rr_arb2, a 2-input round-robin grant with a last_grant register, enabled only in IDLE. Everything else stays in mem_port_arb.

Test Plan:
- Reset check: hold rst_f=0 with if_req=1 -> all outputs 0, busy=0. Release, then if_req=1, if_addr=0x0010, memory[0x10]=0x1234ABCD, RD_LAT=1 -> mem_en at N+1 with mem_addr=0x0010, if_ack at N+3, if_rdata=0x1234ABCD.
- Store: d_req=1, d_we=1, d_addr=0x0020, d_wdata=0xDEADBEEF -> mem_en=1, mem_we=1 at N+1, d_ack at N+2. A follow-up load of 0x0020 returns d_rdata=0xDEADBEEF.
- Conflict: if_req and d_req both rise on the same edge after reset -> fetch is granted first. The data request is granted at the IDLE after the fetch ack. With both held continuously, grants alternate IF, D, IF, D.
- Latency sweep: RD_LAT = 1, 2, 4 with a load of 0x0030=0x00000055 -> d_ack at N+3, N+4, N+6 respectively. mem_en is high for exactly one cycle each time.
- Async reset mid-read: with RD_LAT=4, assert rst_f=0 during WAIT between clock edges -> outputs clear immediately, with no ack ever pulsed. After release, a new request completes normally.
- Stability: change d_addr from 0x0040 to 0x0050 during WAIT -> the access still completes to 0x0040. if_ack and d_ack are never high together over 1000 random cycles.

Source files
------------

// File: rtl/sisc_pkg.sv
// Shared SISC definitions: arbiter state encoding, grant ids
// and default bus widths.
package sisc_pkg;

  localparam int AW_D = 16;
  localparam int DW_D = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; last_grant only advances on an
// enabled grant so a losing request wins the next sample.
module rr_arb2
  import sisc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_f,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic       o_vld,
  output logic       o_id
);

  logic r_last;
  logic w_id;

  always_comb begin
    w_id = GNT_IF;
    unique case (1'b1)
      (i_req[0] & i_req[1]):  w_id = ~r_last;
      (i_req[1] & ~i_req[0]): w_id = GNT_D;
      default:                w_id = GNT_IF;
    endcase
  end

  assign o_vld = i_en & (|i_req);
  assign o_id  = w_id;

  // Reset to DATA so fetch wins the first tie
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f)
      r_last <= GNT_D;
    else if (o_vld)
      r_last <= w_id;
  end

endmodule

// File: rtl/mem_port_arb.sv
// Shares the single-port main memory between instruction fetch
// and data access; one access in flight, all outputs registered.
module mem_port_arb
  import sisc_pkg::*;
#(
  parameter int AW     = AW_D,
  parameter int DW     = DW_D,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_e        r_state;
  state_e        w_nxt;
  logic          w_vld;
  logic          w_id;
  logic          w_we;
  logic          r_gnt;
  logic          r_we;
  logic [2:0]    r_cnt;
  logic          r_if_ack;
  logic          r_d_ack;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_busy;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_f (rst_f),
    .i_en  (r_state == ST_IDLE),
    .i_req ({d_req, if_req}),
    .o_vld (w_vld),
    .o_id  (w_id)
  );

  assign w_we = (w_id == GNT_D) & d_we;

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_vld) w_nxt = ST_ISSUE;
      ST_ISSUE: w_nxt = r_we ? ST_ACK : ST_WAIT;
      ST_WAIT:  if (r_cnt == 3'd1) w_nxt = ST_ACK;
      ST_ACK:   w_nxt = ST_IDLE;
      default:  w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f)
      r_state <= ST_IDLE;
    else
      r_state <= w_nxt;
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_gnt       <= GNT_IF;
      r_we        <= 1'b0;
      r_cnt       <= '0;
      r_if_ack    <= 1'b0;
      r_d_ack     <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_mem_en <= (w_nxt == ST_ISSUE);
      r_mem_we <= 1'b0;
      r_busy   <= (w_nxt != ST_IDLE);
      r_if_ack <= (w_nxt == ST_ACK) && (r_gnt == GNT_IF);
      r_d_ack  <= (w_nxt == ST_ACK) && (r_gnt == GNT_D);
      // Latch the winner so later request changes are ignored
      if (r_state == ST_IDLE && w_vld) begin
        r_gnt      <= w_id;
        r_we       <= w_we;
        r_mem_we   <= w_we;
        r_mem_addr <= (w_id == GNT_D) ? d_addr : if_addr;
        if (w_id == GNT_D)
          r_mem_wdata <= d_wdata;
      end
      if (r_state == ST_ISSUE)
        r_cnt <= LAT;
      else if (r_state == ST_WAIT)
        r_cnt <= r_cnt - 3'd1;
      if (r_state == ST_WAIT && r_cnt == 3'd1) begin
        if (r_gnt == GNT_IF)
          r_if_rdata <= mem_rdata;
        else
          r_d_rdata <= mem_rdata;
      end
    end
  end

  assign if_ack    = r_if_ack;
  assign d_ack     = r_d_ack;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: three instances (RD_LAT 1, 2, 4) with
// memory models, checked against a transaction-level reference.
module tb_mem_port_arb;

  logic        clk = 1'b0;
  logic        rst_f    [3];
  logic        if_req   [3];
  logic [15:0] if_addr  [3];
  logic        if_ack   [3];
  logic [31:0] if_rdata [3];
  logic        d_req    [3];
  logic        d_we     [3];
  logic [15:0] d_addr   [3];
  logic [31:0] d_wdata  [3];
  logic        d_ack    [3];
  logic [31:0] d_rdata  [3];
  logic        mem_en   [3];
  logic        mem_we   [3];
  logic [15:0] mem_addr [3];
  logic [31:0] mem_wdata[3];
  logic [31:0] mem_rdata[3];
  logic        busy     [3];

  int n_err = 0;
  int n_chk = 0;

  logic [31:0] ref_mem [3][256];
  bit          ref_last[3];
  int          en_cnt  [3];
  logic [15:0] en_addr [3];
  logic        en_we   [3];
  logic [31:0] en_wd   [3];

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [7:0] a);
    case (a)
      8'h10:   return 32'h1234ABCD;
      8'h30:   return 32'h00000055;
      8'h40:   return 32'hA5A50040;
      default: return {16'hC3C3, a, ~a};
    endcase
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    logic [31:0] m    [256];
    logic [31:0] pipe [4];

    mem_port_arb #(.AW(16), .DW(32), .RD_LAT(L)) u_dut (
      .clk       (clk),
      .rst_f     (rst_f[g]),
      .if_req    (if_req[g]),
      .if_addr   (if_addr[g]),
      .if_ack    (if_ack[g]),
      .if_rdata  (if_rdata[g]),
      .d_req     (d_req[g]),
      .d_we      (d_we[g]),
      .d_addr    (d_addr[g]),
      .d_wdata   (d_wdata[g]),
      .d_ack     (d_ack[g]),
      .d_rdata   (d_rdata[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g]),
      .busy      (busy[g])
    );

    initial
      for (int a = 0; a < 256; a++) m[a] = init_val(8'(a));

    always @(posedge clk) begin
      if (mem_en[g] && mem_we[g])
        m[mem_addr[g][7:0]] = mem_wdata[g];
      if (mem_en[g] && !mem_we[g])
        pipe[0] <= m[mem_addr[g][7:0]];
      for (int j = 1; j < 4; j++)
        pipe[j] <= pipe[j-1];
    end

    assign mem_rdata[g] = pipe[L-1];
  end

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] outs(input int k);
    return {busy[k], if_ack[k], d_ack[k], mem_en[k], mem_we[k],
            mem_addr[k], mem_wdata[k], if_rdata[k], d_rdata[k]};
  endfunction

  always @(negedge clk)
    for (int i = 0; i < 3; i++) begin
      if (rst_f[i]) begin
        chk("ack_excl", if_ack[i] & d_ack[i], 1'b0);
        chk("we_wo_en", mem_we[i] & ~mem_en[i], 1'b0);
      end
      if (mem_en[i]) begin
        en_cnt[i]++;
        en_addr[i] = mem_addr[i];
        en_we[i]   = mem_we[i];
        en_wd[i]   = mem_wdata[i];
      end
    end

  task automatic wait_idle(input int k);
    int t = 0;
    @(negedge clk);
    while (busy[k] && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("idle_to", busy[k], 1'b0);
  endtask

  task automatic txn(input int k, input bit isd, input bit we,
                     input logic [15:0] a, input logic [31:0] wd,
                     input bit scr);
    int          c = 0;
    int          e0;
    bit          got = 0;
    int          exp_l;
    logic [31:0] rd;
    wait_idle(k);
    e0 = en_cnt[k];
    if (isd) begin
      d_we[k] = we; d_addr[k] = a; d_wdata[k] = wd; d_req[k] = 1'b1;
    end else begin
      if_addr[k] = a; if_req[k] = 1'b1;
    end
    while (!got && c < 40) begin
      @(posedge clk); #1;
      c++;
      if (scr && c == 2) begin
        d_addr[k] = a ^ 16'h0010; d_we[k] = ~we;
        d_wdata[k] = ~wd; if_addr[k] = a ^ 16'h0010;
      end
      got = isd ? d_ack[k] : if_ack[k];
    end
    rd = isd ? d_rdata[k] : if_rdata[k];
    if_req[k] = 1'b0;
    d_req[k]  = 1'b0;
    exp_l = (isd && we) ? 2 : 2 + lat_of(k);
    chk("txn_ack", got, 1'b1);
    chk("txn_lat", c, exp_l);
    chk("txn_en_cnt", en_cnt[k] - e0, 1);
    chk("txn_addr", en_addr[k], a);
    chk("txn_we", en_we[k], isd && we);
    if (isd && we) begin
      chk("txn_wdata", en_wd[k], wd);
      ref_mem[k][a[7:0]] = wd;
    end else
      chk("txn_rdata", rd, ref_mem[k][a[7:0]]);
    ref_last[k] = isd;
  endtask

  // Both requesters raised together; hold keeps them high so every
  // ack is immediately followed by a fresh request from that side.
  task automatic pair(input int k, input logic [15:0] ia,
                      input logic [15:0] da, input bit dwe,
                      input logic [31:0] dwd, input bit hold,
                      input int nacks);
    int c = 0;
    int n = 0;
    int e0;
    int texp;
    bit who;
    bit who_exp;
    wait_idle(k);
    e0 = en_cnt[k];
    if_addr[k] = ia; if_req[k] = 1'b1;
    d_addr[k] = da; d_we[k] = dwe; d_wdata[k] = dwd; d_req[k] = 1'b1;
    who_exp = ~ref_last[k];
    texp = 2 + ((who_exp && dwe) ? 0 : lat_of(k));
    while (n < nacks && c < 100) begin
      @(posedge clk); #1;
      c++;
      if (if_ack[k] || d_ack[k]) begin
        who = d_ack[k];
        chk("pair_who", who, who_exp);
        chk("pair_time", c, texp);
        if (!who)
          chk("pair_if_rdata", if_rdata[k], ref_mem[k][ia[7:0]]);
        else if (dwe)
          ref_mem[k][da[7:0]] = dwd;
        else
          chk("pair_d_rdata", d_rdata[k], ref_mem[k][da[7:0]]);
        ref_last[k] = who;
        if (!hold) begin
          if (who) d_req[k] = 1'b0;
          else     if_req[k] = 1'b0;
        end
        n++;
        who_exp = ~ref_last[k];
        texp = texp + 3 + ((who_exp && dwe) ? 0 : lat_of(k));
      end
    end
    if_req[k] = 1'b0;
    d_req[k]  = 1'b0;
    chk("pair_acks", n, nacks);
    chk("pair_en_cnt", en_cnt[k] - e0, nacks);
  endtask

  task automatic rnd(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      int          r  = $urandom_range(0, 3);
      logic [15:0] a  = 16'($urandom_range(0, 255));
      logic [15:0] a2 = 16'($urandom_range(0, 255));
      logic [31:0] wd = $urandom;
      bit          h  = 1'($urandom_range(0, 1));
      if (r == 3)
        pair(k, a, a2, 1'($urandom_range(0, 1)), wd, h,
             h ? $urandom_range(2, 4) : 2);
      else
        txn(k, r != 0, r == 2, a, wd, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int  c;
    bit  got;
    for (int k = 0; k < 3; k++) begin
      rst_f[k] = 1'b0; if_req[k] = 1'b0; d_req[k] = 1'b0;
      if_addr[k] = '0; d_we[k] = 1'b0; d_addr[k] = '0;
      d_wdata[k] = '0; ref_last[k] = 1'b1; en_cnt[k] = 0;
      for (int a = 0; a < 256; a++) ref_mem[k][a] = init_val(8'(a));
    end
    if_req[0] = 1'b1;
    if_addr[0] = 16'h0010;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) chk("reset_outs", outs(k), '0);

    // Reset release with fetch already requested on instance 0
    for (int k = 0; k < 3; k++) rst_f[k] = 1'b1;
    c = 0;
    got = 0;
    while (!got && c < 20) begin
      @(posedge clk); #1;
      c++;
      if (c == 1) begin
        chk("rst_fetch_en", mem_en[0], 1'b1);
        chk("rst_fetch_addr", mem_addr[0], 16'h0010);
      end
      got = if_ack[0];
    end
    chk("rst_fetch_ack_cyc", c, 3);
    chk("rst_fetch_rdata", if_rdata[0], 32'h1234ABCD);
    if_req[0] = 1'b0;
    ref_last[0] = 1'b0;

    txn(0, 1'b1, 1'b1, 16'h0020, 32'hDEADBEEF, 1'b0);
    txn(0, 1'b1, 1'b0, 16'h0020, 32'h0, 1'b0);
    chk("store_load_back", d_rdata[0], 32'hDEADBEEF);

    pair(1, 16'h0011, 16'h0022, 1'b0, 32'h0, 1'b0, 2);
    pair(1, 16'h0033, 16'h0044, 1'b0, 32'h0, 1'b1, 4);

    for (int k = 0; k < 3; k++) begin
      txn(k, 1'b1, 1'b0, 16'h0030, 32'h0, 1'b0);
      chk("sweep_rdata", d_rdata[k], 32'h00000055);
    end

    txn(2, 1'b1, 1'b0, 16'h0040, 32'h0, 1'b1);
    chk("stable_rdata", d_rdata[2], 32'hA5A50040);

    // Asynchronous reset in the middle of a RD_LAT=4 read
    wait_idle(2);
    d_we[2] = 1'b0; d_addr[2] = 16'h0030; d_req[2] = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst_f[2] = 1'b0;
    #1;
    chk("midrst_outs", outs(2), '0);
    d_req[2] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_ack", d_ack[2] | if_ack[2], 1'b0);
    end
    rst_f[2] = 1'b1;
    ref_last[2] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("postrst_no_ack", d_ack[2] | if_ack[2], 1'b0);
    end
    txn(2, 1'b1, 1'b0, 16'h0030, 32'h0, 1'b0);

    fork
      rnd(0, 100);
      rnd(1, 80);
      rnd(2, 60);
    join

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
